// File: rtl/uart_tx_scheduler_pkg.sv
// Shared constants and state encoding for the UART TX scheduler.
// Address map of the peripheral block plus the scheduler FSM states.
package uart_tx_scheduler_pkg;

    localparam logic [31:0] ADDR_TX_DATA   = 32'h4000_0018;
    localparam logic [31:0] ADDR_UART_STAT = 32'h4000_0020;
    localparam logic [31:0] ADDR_Q_PUSH    = 32'h4000_0024;
    localparam logic [31:0] ADDR_Q_STAT    = 32'h4000_0028;

    localparam int unsigned TX_BUSY_BIT = 4;

    typedef enum logic [2:0] {
        StIdle,
        StPoll,
        StSend,
        StHold,
        StGap
    } sched_state_e;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Simple strobe-based memory bus: single-cycle read/write with same-cycle read data.
// The master drives the strobes, address and write data; the slave returns read data.
interface uart_tx_scheduler_if;

    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, output wr, output addr, output wdata, input rdata);
    modport slave  (input rd, input wr, input addr, input wdata, output rdata);

endinterface

// File: rtl/uart_tx_scheduler_sync_byte_fifo.sv
// Single-clock byte FIFO with level count; pushes while full and pops while empty are ignored.
// Full/empty are evaluated on the current level, so a pop never makes room for a same-cycle push.
module sync_byte_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [7:0]    push_data_i,
    input  logic          pop_i,
    output logic [7:0]    head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign full_o  = (level_q == (AW + 1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Bus bridge between CPU and peripheral block that drains a CPU-filled byte queue into the
// UART TX register during idle bus cycles, polling the UART busy flag before each byte.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AW          = 4,
    parameter int unsigned POLL_GAP    = 4,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_scheduler_if.slave   cpu,
    uart_tx_scheduler_if.master  per
);

    localparam int unsigned CNT_W = 8;

    sched_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    logic        cpu_busy;
    logic        hit_push, hit_stat, local_hit;
    logic        q_push, q_pop, q_full, q_empty;
    logic [7:0]  q_head;
    logic [AW:0] q_level;
    logic [31:0] q_stat;

    assign cpu_busy  = cpu.rd | cpu.wr;
    assign hit_push  = (cpu.addr == ADDR_Q_PUSH);
    assign hit_stat  = (cpu.addr == ADDR_Q_STAT);
    assign local_hit = hit_push | hit_stat;

    assign q_push = cpu.wr & hit_push;
    assign q_pop  = ~cpu_busy & (state_q == StSend);

    sync_byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (q_push),
        .push_data_i (cpu.wdata[7:0]),
        .pop_i       (q_pop),
        .head_o      (q_head),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .level_o     (q_level)
    );

    always_comb begin
        q_stat         = '0;
        q_stat[AW:0]   = q_level;
        q_stat[AW + 1] = q_empty;
        q_stat[AW + 2] = q_full;
        q_stat[AW + 3] = ovf_q;
    end

    always_comb begin
        cpu.rdata = '0;
        if (cpu.rd) begin
            if (hit_stat)      cpu.rdata = q_stat;
            else if (!hit_push) cpu.rdata = per.rdata;
        end
    end

    // Any CPU strobe owns the bus, even for local addresses; the scheduler only fills gaps.
    always_comb begin
        per.rd    = 1'b0;
        per.wr    = 1'b0;
        per.addr  = '0;
        per.wdata = '0;
        if (cpu_busy) begin
            per.rd    = cpu.rd & ~local_hit;
            per.wr    = cpu.wr & ~local_hit;
            per.addr  = cpu.addr;
            per.wdata = cpu.wdata;
        end else begin
            case (state_q)
                StPoll: begin
                    per.rd   = 1'b1;
                    per.addr = ADDR_UART_STAT;
                end
                StSend: begin
                    per.wr    = 1'b1;
                    per.addr  = ADDR_TX_DATA;
                    per.wdata = {24'h0, q_head};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (q_push && q_full)          ovf_q <= 1'b1;
            else if (cpu.rd && hit_stat)   ovf_q <= 1'b0;

            if (!cpu_busy) begin
                case (state_q)
                    StIdle: if (!q_empty) state_q <= StPoll;
                    StPoll: begin
                        if (per.rdata[TX_BUSY_BIT]) begin
                            cnt_q   <= CNT_W'(POLL_GAP - 1);
                            state_q <= StGap;
                        end else begin
                            state_q <= StSend;
                        end
                    end
                    StSend: begin
                        cnt_q   <= CNT_W'(HOLD_CYCLES - 1);
                        state_q <= StHold;
                    end
                    // Leaving as the count reaches zero keeps the wait, IDLE included, at N cycles.
                    StHold, StGap: begin
                        if (cnt_q <= CNT_W'(1)) begin
                            cnt_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
